// File: rtl/axi_pkg.sv
// Shared AXI types, burst encodings and address/lane helper functions.
// Address helpers operate on a 64-bit address; callers zero-extend narrower buses.
package axi_pkg;

    typedef logic [1:0] burst_t;
    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;

    localparam int unsigned MaxAddrWidth = 64;
    typedef logic [MaxAddrWidth-1:0] addr_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;
    localparam burst_t BURST_RSVD  = 2'b11;

    // Bytes transferred per beat for a given AxSIZE.
    function automatic logic [7:0] num_bytes(size_t size);
        return 8'd1 << size;
    endfunction

    // Address rounded down to the beat size.
    function automatic addr_t aligned_addr(addr_t addr, size_t size);
        return addr & ~((addr_t'(1) << size) - addr_t'(1));
    endfunction

    // Lowest address of the wrap container. Legal wrap lengths (2/4/8/16 beats)
    // make the container a power of two, so the division reduces to a mask.
    function automatic addr_t wrap_boundary(addr_t addr, size_t size, len_t len);
        addr_t container;
        container = (addr_t'(len) + addr_t'(1)) << size;
        return addr & ~(container - addr_t'(1));
    endfunction

    // First active byte lane of a beat on a bus of bus_bytes lanes.
    function automatic int unsigned beat_lower_byte(addr_t addr, int unsigned bus_bytes);
        return 32'(addr & addr_t'(bus_bytes - 1));
    endfunction

    // Last active byte lane of a beat; may exceed the bus width for oversize requests.
    function automatic int unsigned beat_upper_byte(addr_t addr, size_t size,
                                                    int unsigned bus_bytes);
        addr_t bus_base;
        bus_base = addr & ~addr_t'(bus_bytes - 1);
        return 32'(aligned_addr(addr, size) + addr_t'(num_bytes(size)) - addr_t'(1) - bus_base);
    endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Expands one AXI address request into per-beat address, index, strobe and last/err flags.
// Erroneous requests still produce len+1 beats, walked as INCR, so downstream beat counts hold.
module axi_beat_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ax_valid_i,
    output logic                 ax_ready_o,
    input  logic [AddrWidth-1:0] ax_addr_i,
    input  len_t                 ax_len_i,
    input  size_t                ax_size_i,
    input  burst_t               ax_burst_i,
    output logic                 beat_valid_o,
    input  logic                 beat_ready_i,
    output logic [AddrWidth-1:0] beat_addr_o,
    output logic [7:0]           beat_idx_o,
    output logic [StrbWidth-1:0] beat_strb_o,
    output logic                 beat_last_o,
    output logic                 beat_err_o
);

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e               state_q, state_d;
    burst_t               mode_q, mode_d;
    size_t                size_q, size_d;
    len_t                 len_q, len_d;
    logic [AddrWidth-1:0] wrap_lo_q, wrap_lo_d;
    logic [AddrWidth-1:0] wrap_hi_q, wrap_hi_d;
    logic                 valid_q, valid_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           idx_q, idx_d;
    logic [StrbWidth-1:0] strb_q, strb_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic  ax_fire;
    logic  beat_fire;
    logic  req_err;
    logic  wrap_len_ok;
    addr_t ax_addr_w;
    addr_t cur_addr_w;
    addr_t step_w;
    addr_t next_w;
    addr_t req_lo_w;
    addr_t req_hi_w;
    logic  unused_bits;

    // Byte lanes lower..upper of the beat at addr, clipped to the bus width.
    function automatic logic [StrbWidth-1:0] lane_mask(addr_t addr, size_t size);
        logic [StrbWidth-1:0] mask;
        int unsigned          lo;
        int unsigned          hi;
        lo   = beat_lower_byte(addr, StrbWidth);
        hi   = beat_upper_byte(addr, size, StrbWidth);
        mask = '0;
        for (int unsigned i = 0; i < StrbWidth; i++) begin
            mask[i] = (i >= lo) && (i <= hi);
        end
        return mask;
    endfunction

    assign beat_fire  = valid_q & beat_ready_i;
    assign ax_ready_o = (state_q == IDLE) | (beat_fire & last_q);
    assign ax_fire    = ax_valid_i & ax_ready_o;

    assign beat_valid_o = valid_q;
    assign beat_addr_o  = addr_q;
    assign beat_idx_o   = idx_q;
    assign beat_strb_o  = strb_q;
    assign beat_last_o  = last_q;
    assign beat_err_o   = err_q;

    assign unused_bits = ^{step_w, next_w, req_lo_w, req_hi_w};

    // Decode an incoming request: legality and the wrap window it would use.
    always_comb begin
        ax_addr_w   = addr_t'(ax_addr_i);
        wrap_len_ok = (ax_len_i == 8'd1) || (ax_len_i == 8'd3) ||
                      (ax_len_i == 8'd7) || (ax_len_i == 8'd15);
        req_err     = (ax_burst_i == BURST_RSVD) ||
                      ((ax_burst_i == BURST_WRAP) && !wrap_len_ok) ||
                      ((ax_burst_i == BURST_WRAP) &&
                       (ax_addr_w != aligned_addr(ax_addr_w, ax_size_i))) ||
                      (32'(num_bytes(ax_size_i)) > StrbWidth);
        req_lo_w    = wrap_boundary(ax_addr_w, ax_size_i, ax_len_i);
        req_hi_w    = req_lo_w + ((addr_t'(ax_len_i) + addr_t'(1)) << ax_size_i);
    end

    // Address of the beat following the one currently presented.
    always_comb begin
        cur_addr_w = addr_t'(addr_q);
        step_w     = cur_addr_w + addr_t'(num_bytes(size_q));
        next_w     = aligned_addr(cur_addr_w, size_q) + addr_t'(num_bytes(size_q));
        case (mode_q)
            BURST_FIXED: next_w = cur_addr_w;
            BURST_WRAP: begin
                next_w = step_w;
                if (step_w[AddrWidth-1:0] == wrap_hi_q) begin
                    next_w = addr_t'(wrap_lo_q);
                end
            end
            default: ;
        endcase
    end

    // Next-state and next-beat selection: new request, beat advance, or hold.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        size_d    = size_q;
        len_d     = len_q;
        wrap_lo_d = wrap_lo_q;
        wrap_hi_d = wrap_hi_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        strb_d    = strb_q;
        last_d    = last_q;
        err_d     = err_q;

        if (ax_fire) begin
            state_d   = BURST;
            mode_d    = req_err ? BURST_INCR : ax_burst_i;
            size_d    = ax_size_i;
            len_d     = ax_len_i;
            wrap_lo_d = req_lo_w[AddrWidth-1:0];
            wrap_hi_d = req_hi_w[AddrWidth-1:0];
            valid_d   = 1'b1;
            addr_d    = ax_addr_i;
            idx_d     = 8'd0;
            strb_d    = lane_mask(ax_addr_w, ax_size_i);
            last_d    = (ax_len_i == 8'd0);
            err_d     = req_err;
        end else if (beat_fire) begin
            if (last_q) begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end else begin
                addr_d = next_w[AddrWidth-1:0];
                idx_d  = idx_q + 8'd1;
                strb_d = lane_mask(next_w, size_q);
                last_d = ((idx_q + 8'd1) == len_q);
            end
        end
    end

    // Burst context and registered beat outputs, cleared asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            mode_q    <= BURST_FIXED;
            size_q    <= '0;
            len_q     <= '0;
            wrap_lo_q <= '0;
            wrap_hi_q <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            idx_q     <= '0;
            strb_q    <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            size_q    <= size_d;
            len_q     <= len_d;
            wrap_lo_q <= wrap_lo_d;
            wrap_hi_q <= wrap_hi_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            strb_q    <= strb_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_beat_addr_gen.sv
// Directed bench for axi_beat_addr_gen: INCR, WRAP, FIXED, back-to-back, stall,
// illegal WRAP and mid-burst reset, with hand-computed beat expectations.
module tb_axi_beat_addr_gen;
    import axi_pkg::*;

    logic        clk;
    logic        rstN;
    logic        axValid;
    logic        axReady;
    logic [31:0] axAddr;
    len_t        axLen;
    size_t       axSize;
    burst_t      axBurst;
    logic        beatValid;
    logic        beatReady;
    logic [31:0] beatAddr;
    logic [7:0]  beatIdx;
    logic [7:0]  beatStrb;
    logic        beatLast;
    logic        beatErr;

    int testCount = 0;
    int failCount = 0;

    axi_beat_addr_gen #(
        .AddrWidth(32),
        .DataWidth(64)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .ax_valid_i  (axValid),
        .ax_ready_o  (axReady),
        .ax_addr_i   (axAddr),
        .ax_len_i    (axLen),
        .ax_size_i   (axSize),
        .ax_burst_i  (axBurst),
        .beat_valid_o(beatValid),
        .beat_ready_i(beatReady),
        .beat_addr_o (beatAddr),
        .beat_idx_o  (beatIdx),
        .beat_strb_o (beatStrb),
        .beat_last_o (beatLast),
        .beat_err_o  (beatErr)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst,
                                 input logic bready);
        axValid   = v;
        axAddr    = addr;
        axLen     = len;
        axSize    = size;
        axBurst   = burst;
        beatReady = bready;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] addr, input logic [7:0] idx,
                             input logic [7:0] strb, input logic last, input logic err);
        #1;
        checkOutput({tag, ".valid"}, 64'(beatValid), 64'd1);
        checkOutput({tag, ".addr"},  64'(beatAddr),  64'(addr));
        checkOutput({tag, ".idx"},   64'(beatIdx),   64'(idx));
        checkOutput({tag, ".strb"},  64'(beatStrb),  64'(strb));
        checkOutput({tag, ".last"},  64'(beatLast),  64'(last));
        checkOutput({tag, ".err"},   64'(beatErr),   64'(err));
    endtask

    task automatic checkIdle(input string tag);
        #1;
        checkOutput({tag, ".valid"},   64'(beatValid), 64'd0);
        checkOutput({tag, ".axready"}, 64'(axReady),   64'd1);
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0, BURST_INCR, 1'b1);

        // reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst.valid", 64'(beatValid), 64'd0);
        checkOutput("rst.addr",  64'(beatAddr),  64'd0);
        checkOutput("rst.idx",   64'(beatIdx),   64'd0);
        checkOutput("rst.strb",  64'(beatStrb),  64'd0);
        checkOutput("rst.last",  64'(beatLast),  64'd0);
        checkOutput("rst.err",   64'(beatErr),   64'd0);
        @(negedge clk);
        rstN = 1'b1;
        checkIdle("rst.release");

        // INCR unaligned, size 2, len 3
        @(negedge clk);
        applyStimulus(1'b1, 32'h1003, 8'd3, 3'd2, BURST_INCR, 1'b1);
        #1 checkOutput("incr.axready", 64'(axReady), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0, BURST_INCR, 1'b1);
        checkBeat("incr.b0", 32'h1003, 8'd0, 8'h08, 1'b0, 1'b0);
        checkOutput("incr.b0.axready", 64'(axReady), 64'd0);
        @(negedge clk) checkBeat("incr.b1", 32'h1004, 8'd1, 8'hF0, 1'b0, 1'b0);
        @(negedge clk) checkBeat("incr.b2", 32'h1008, 8'd2, 8'h0F, 1'b0, 1'b0);
        @(negedge clk) checkBeat("incr.b3", 32'h100C, 8'd3, 8'hF0, 1'b1, 1'b0);
        checkOutput("incr.b3.axready", 64'(axReady), 64'd1);
        @(negedge clk) checkIdle("incr.done");

        // WRAP size 3, len 3 from mid-container
        @(negedge clk);
        applyStimulus(1'b1, 32'h2018, 8'd3, 3'd3, BURST_WRAP, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0, BURST_INCR, 1'b1);
        checkBeat("wrap.b0", 32'h2018, 8'd0, 8'hFF, 1'b0, 1'b0);
        @(negedge clk) checkBeat("wrap.b1", 32'h2000, 8'd1, 8'hFF, 1'b0, 1'b0);
        @(negedge clk) checkBeat("wrap.b2", 32'h2008, 8'd2, 8'hFF, 1'b0, 1'b0);
        @(negedge clk) checkBeat("wrap.b3", 32'h2010, 8'd3, 8'hFF, 1'b1, 1'b0);
        @(negedge clk) checkIdle("wrap.done");

        // FIXED size 1, len 2
        @(negedge clk);
        applyStimulus(1'b1, 32'h3002, 8'd2, 3'd1, BURST_FIXED, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0, BURST_INCR, 1'b1);
        checkBeat("fixed.b0", 32'h3002, 8'd0, 8'h0C, 1'b0, 1'b0);
        @(negedge clk) checkBeat("fixed.b1", 32'h3002, 8'd1, 8'h0C, 1'b0, 1'b0);
        @(negedge clk) checkBeat("fixed.b2", 32'h3002, 8'd2, 8'h0C, 1'b1, 1'b0);
        @(negedge clk) checkIdle("fixed.done");

        // back-to-back single-beat bursts, no bubbles
        @(negedge clk);
        applyStimulus(1'b1, 32'h5000, 8'd0, 3'd3, BURST_INCR, 1'b1);
        #1 checkOutput("b2b.axready0", 64'(axReady), 64'd1);
        @(negedge clk);
        applyStimulus(1'b1, 32'h5008, 8'd0, 3'd3, BURST_INCR, 1'b1);
        checkBeat("b2b.b0", 32'h5000, 8'd0, 8'hFF, 1'b1, 1'b0);
        checkOutput("b2b.axready1", 64'(axReady), 64'd1);
        @(negedge clk);
        applyStimulus(1'b1, 32'h5010, 8'd0, 3'd3, BURST_INCR, 1'b1);
        checkBeat("b2b.b1", 32'h5008, 8'd0, 8'hFF, 1'b1, 1'b0);
        checkOutput("b2b.axready2", 64'(axReady), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0, BURST_INCR, 1'b1);
        checkBeat("b2b.b2", 32'h5010, 8'd0, 8'hFF, 1'b1, 1'b0);
        checkOutput("b2b.axready3", 64'(axReady), 64'd1);
        @(negedge clk) checkIdle("b2b.done");

        // INCR with a 5-cycle stall on beat 1
        @(negedge clk);
        applyStimulus(1'b1, 32'h1003, 8'd3, 3'd2, BURST_INCR, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0, BURST_INCR, 1'b1);
        checkBeat("stall.b0", 32'h1003, 8'd0, 8'h08, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            beatReady = 1'b0;
            checkBeat($sformatf("stall.hold%0d", i), 32'h1004, 8'd1, 8'hF0, 1'b0, 1'b0);
            checkOutput($sformatf("stall.axready%0d", i), 64'(axReady), 64'd0);
        end
        @(negedge clk);
        beatReady = 1'b1;
        checkBeat("stall.b1", 32'h1004, 8'd1, 8'hF0, 1'b0, 1'b0);
        @(negedge clk) checkBeat("stall.b2", 32'h1008, 8'd2, 8'h0F, 1'b0, 1'b0);
        @(negedge clk) checkBeat("stall.b3", 32'h100C, 8'd3, 8'hF0, 1'b1, 1'b0);
        @(negedge clk) checkIdle("stall.done");

        // illegal WRAP length walks as INCR with err flagged
        @(negedge clk);
        applyStimulus(1'b1, 32'h4000, 8'd2, 3'd2, BURST_WRAP, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0, BURST_INCR, 1'b1);
        checkBeat("werr.b0", 32'h4000, 8'd0, 8'h0F, 1'b0, 1'b1);
        @(negedge clk) checkBeat("werr.b1", 32'h4004, 8'd1, 8'hF0, 1'b0, 1'b1);
        @(negedge clk) checkBeat("werr.b2", 32'h4008, 8'd2, 8'h0F, 1'b1, 1'b1);
        @(negedge clk) checkIdle("werr.done");

        // reset asserted during beat 2
        @(negedge clk);
        applyStimulus(1'b1, 32'h1003, 8'd3, 3'd2, BURST_INCR, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0, BURST_INCR, 1'b1);
        checkBeat("mrst.b0", 32'h1003, 8'd0, 8'h08, 1'b0, 1'b0);
        @(negedge clk) checkBeat("mrst.b1", 32'h1004, 8'd1, 8'hF0, 1'b0, 1'b0);
        @(negedge clk) checkBeat("mrst.b2", 32'h1008, 8'd2, 8'h0F, 1'b0, 1'b0);
        #1 rstN = 1'b0;
        #1;
        checkOutput("mrst.valid", 64'(beatValid), 64'd0);
        checkOutput("mrst.addr",  64'(beatAddr),  64'd0);
        checkOutput("mrst.idx",   64'(beatIdx),   64'd0);
        checkOutput("mrst.strb",  64'(beatStrb),  64'd0);
        checkOutput("mrst.last",  64'(beatLast),  64'd0);
        @(negedge clk);
        rstN = 1'b1;
        checkIdle("mrst.release");
        @(negedge clk) checkIdle("mrst.quiet1");
        @(negedge clk) checkIdle("mrst.quiet2");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/axi_beat_addr_gen.md
AXI_BEAT_ADDR_GEN -- requirements
Module: axi_beat_addr_gen

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, which sets the address width in bits.
REQ-002 SHALL have parameter DataWidth, default 64, which sets the data bus width in bits; StrbWidth = DataWidth/8.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have the following AX request ports:
- ax_valid_i, input, 1 bit.
- ax_ready_o, output, 1 bit.
- ax_addr_i, input, AddrWidth bits.
- ax_len_i, input, axi_pkg::len_t.
- ax_size_i, input, axi_pkg::size_t.
- ax_burst_i, input, axi_pkg::burst_t.
REQ-006 SHALL have the following beat output ports:
- beat_valid_o, output, 1 bit.
- beat_ready_i, input, 1 bit.
- beat_addr_o, output, AddrWidth bits, the beat address.
- beat_idx_o, output, 8 bits, the beat number.
- beat_strb_o, output, StrbWidth bits, the active byte lanes.
- beat_last_o, output, 1 bit, the final beat.
- beat_err_o, output, 1 bit, an illegal request.

Function
REQ-007 SHALL use two states, IDLE and BURST, with IDLE after reset.
REQ-008 SHALL drive ax_ready_o = (state==IDLE) | (beat_valid_o & beat_ready_i & beat_last_o), so back-to-back bursts have zero bubble cycles.
REQ-009 SHALL capture addr, len, size and burst on an AX handshake, and present beat 0 with beat_valid_o=1 in the next cycle (latency 1).
REQ-010 SHALL register all beat_* outputs; they SHALL hold stable while beat_valid_o & ~beat_ready_i.
REQ-011 SHALL advance to the next beat on a beat handshake: beat_idx_o increments, and beat_last_o = (beat_idx_o == len).
REQ-012 SHALL, on a handshake of the last beat with no new AX handshake, enter IDLE and deassert beat_valid_o in the next cycle.
REQ-013 SHALL generate beat addresses per burst type:
- FIXED: every beat uses ax_addr.
- INCR: beat 0 uses ax_addr; beat i uses aligned_addr(ax_addr,size) + i*num_bytes(size), modulo 2^AddrWidth.
- 4 KiB crossing is not checked.
REQ-014 SHALL generate WRAP addresses as follows:
- Container = num_bytes(size)*(len+1).
- Boundary = (ax_addr/container)*container.
- The address increments by num_bytes(size); on reaching boundary+container it returns to boundary.
REQ-015 SHALL compute beat_strb_o as lanes lower..upper set, using the axi_pkg beat_lower_byte / beat_upper_byte rules:
- beat 0 of INCR uses the unaligned lower lane.
- FIXED repeats the beat-0 lanes.
REQ-016 SHALL assert beat_err_o on every beat of a burst that meets any of these conditions:
- burst==2'b11; or
- WRAP with len not in {1,3,7,15}; or
- WRAP with ax_addr not size-aligned; or
- num_bytes(size) > StrbWidth.
REQ-017 SHALL process an erroneous burst as INCR for the full len+1 beats, so the beat count is preserved.
REQ-018 SHALL handle len==0 as a single beat with beat_last_o=1 and beat_idx_o=0.

Reset
REQ-019 SHALL, while rst_ni=0, asynchronously force the following:
- state=IDLE.
- beat_valid_o=0, beat_last_o=0, beat_err_o=0.
- beat_addr_o, beat_idx_o and beat_strb_o all 0.
REQ-020 SHALL discard any burst in progress on reset, with no beats emitted after release until a new AX handshake.
REQ-021 SHALL drive ax_ready_o=1 in the first cycle after reset release.

Structure
REQ-022 SHALL use burst_t, len_t, size_t, BURST_*, num_bytes and aligned_addr from axi_pkg.
REQ-023 SHALL add function wrap_boundary(addr,size,len) to axi_pkg for reuse by other blocks.
REQ-024 SHALL be a single module with no sub-module; lane-mask generation is an internal combinational function.

Verification
All scenarios run with DataWidth=64.
REQ-025 SHALL cover INCR with addr 0x1003, size 2, len 3 -> addresses 0x1003, 0x1004, 0x1008, 0x100C; strobes 0x08, 0xF0, 0x0F, 0xF0; last on beat 3.
REQ-026 SHALL cover WRAP with addr 0x2018, size 3, len 3 -> addresses 0x2018, 0x2000, 0x2008, 0x2010; strobes 0xFF; beat_err_o=0.
REQ-027 SHALL cover FIXED with addr 0x3002, size 1, len 2 -> three beats at 0x3002, strobe 0x0C, last on beat 2.
REQ-028 SHALL cover back-to-back len 0 bursts with beat_ready_i held at 1 -> beat_valid_o stays high continuously and ax_ready_o=1 in every cycle.
REQ-029 SHALL cover beat_ready_i low for 5 cycles at beat 1 of the REQ-025 burst -> all outputs stable during the stall, then the burst resumes at 0x1008.
REQ-030 SHALL cover WRAP with len 2 -> 3 beats with INCR addresses and beat_err_o=1.
REQ-031 SHALL cover rst_ni pulsed low at beat 2 -> beat_valid_o=0 immediately and ax_ready_o=1 after release.
